// File: rtl/reduction_a_maxpool.sv
// ---------------------------------------------------------------------------
// reduction_a_maxpool
//
// 3x3 max-pool, stride 2, no padding, over a D x D single-channel frame of
// IEEE-754 pixels delivered in raster order. Each output edge has
// (D-3)/2+1 pixels.
//
// Ordering is the sign-magnitude order of the raw encoding. +0 and -0 compare
// equal. NaNs are ordered by their encoding. On a tie the earliest window
// element in raster order wins.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-low
//   valid_in   in   qualifies pxl_in
//   pxl_in     in   DATA_WIDTH input pixel, raster order
//   pxl_out    out  DATA_WIDTH pooled pixel, holds while valid_out is low
//   valid_out  out  one-cycle pulse per pooled pixel
//   frame_end  out  high with the last pooled pixel of a frame
//
// Optional feature: define MAXPOOL_RELU_EN to force any result with its sign
// bit set (including -0) to zero. Latency is unchanged.
// ---------------------------------------------------------------------------
module reduction_a_maxpool #(
  parameter int DATA_WIDTH = 32,
  parameter int D          = 35
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_end
);

  localparam int              CW   = $clog2(D);
  localparam logic [CW-1:0]   LAST = CW'(D - 1);
  localparam logic [CW-1:0]   TWO  = CW'(2);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  // Map an encoding to an unsigned key whose natural order is the
  // sign-magnitude order. Non-negatives (and -0) take {1, magnitude}, so -0
  // lands on the same key as +0. Other negatives take the bitwise inverse,
  // which places them below every non-negative key, with larger magnitudes
  // lower.
  function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] k;
    if (!x[DATA_WIDTH-1] || (x[DATA_WIDTH-2:0] == '0)) begin
      k = {1'b1, x[DATA_WIDTH-2:0]};
    end else begin
      k = ~x;
    end
    return k;
  endfunction

  // Strictly greater, so that on a tie the earlier candidate is kept.
  function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                              input logic [DATA_WIDTH-1:0] b);
    return order_key(a) > order_key(b);
  endfunction

  // -------------------------------------------------------------------------
  // Position counters
  // -------------------------------------------------------------------------
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          launch_d, last_d;

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    launch_d = 1'b0;
    last_d   = 1'b0;
    if (valid_in) begin
      // This pixel completes a window when it sits on an even row and an
      // even column, both at least 2.
      launch_d = (row_q >= TWO) && (col_q >= TWO) && !row_q[0] && !col_q[0];
      last_d   = (row_q == LAST) && (col_q == LAST);
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // -------------------------------------------------------------------------
  // Line buffers and 3x3 window (data only, not reset)
  // lb1 holds the previous row and lb2 the row before it. win_q is indexed
  // [row][col]: row 0 is the top row, col 2 is the newest column.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] lb1_q [D];
  logic [DATA_WIDTH-1:0] lb2_q [D];
  logic [DATA_WIDTH-1:0] win_q [3][3];

  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb2_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= pxl_in;
      for (int unsigned r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb2_q[col_q];
      win_q[1][2] <= lb1_q[col_q];
      win_q[2][2] <= pxl_in;
    end
  end

  // -------------------------------------------------------------------------
  // Reduction pipeline. It advances every cycle.
  //   edge 0: the bottom-right pixel is accepted; window and launch_q update
  //   edge 1: per-row maxima are registered
  //   edge 2: the final maximum is registered onto pxl_out / valid_out
  // -------------------------------------------------------------------------
  logic                  launch_q, last_q;
  logic                  s1_valid_q, s1_last_q;
  logic [DATA_WIDTH-1:0] s1_row_d [3];
  logic [DATA_WIDTH-1:0] s1_row_q [3];

  // Row maxima: leftmost wins ties within a row.
  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      s1_row_d[r] = win_q[r][0];
      if (gt(win_q[r][1], s1_row_d[r])) s1_row_d[r] = win_q[r][1];
      if (gt(win_q[r][2], s1_row_d[r])) s1_row_d[r] = win_q[r][2];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < 3; r++) begin
      s1_row_q[r] <= s1_row_d[r];
    end
  end

  // Column maximum over the row winners: the top row wins ties, which keeps
  // the overall winner the earliest element in raster order.
  logic [DATA_WIDTH-1:0] max_s2;
  logic [DATA_WIDTH-1:0] res_s2;
  logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
  logic                  valid_out_q, frame_end_q;

  always_comb begin
    max_s2 = s1_row_q[0];
    if (gt(s1_row_q[1], max_s2)) max_s2 = s1_row_q[1];
    if (gt(s1_row_q[2], max_s2)) max_s2 = s1_row_q[2];
`ifdef MAXPOOL_RELU_EN
    res_s2 = max_s2[DATA_WIDTH-1] ? '0 : max_s2;
`else
    res_s2 = max_s2;
`endif
    pxl_out_d = s1_valid_q ? res_s2 : pxl_out_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      launch_q    <= 1'b0;
      last_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      valid_out_q <= 1'b0;
      frame_end_q <= 1'b0;
      pxl_out_q   <= '0;
    end else begin
      launch_q    <= launch_d;
      last_q      <= last_d;
      s1_valid_q  <= launch_q;
      s1_last_q   <= last_q;
      valid_out_q <= s1_valid_q;
      frame_end_q <= s1_valid_q && s1_last_q;
      pxl_out_q   <= pxl_out_d;
    end
  end

  assign pxl_out   = pxl_out_q;
  assign valid_out = valid_out_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_reduction_a_maxpool.sv
module tb_reduction_a_maxpool;

  localparam int DW   = 32;
  localparam int D    = 35;
  localparam int OE   = (D - 3) / 2 + 1;
  localparam int NPIX = D * D;
  localparam int NOUT = OE * OE;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] pxl_in;
  logic [DW-1:0] pxl_out;
  logic          valid_out;
  logic          frame_end;

  reduction_a_maxpool #(.DATA_WIDTH(DW), .D(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .pxl_in    (pxl_in),
    .pxl_out   (pxl_out),
    .valid_out (valid_out),
    .frame_end (frame_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic        fe;
    int unsigned c;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        got_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned stray_fe = 0;

  // Reference frame, indexed [row][col]
  logic [31:0] fr [D][D];
  int          mrow = 0;
  int          mcol = 0;

  // Output capture: every pulse is recorded with the edge count it appeared on.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (valid_out) got_q.push_back('{v: pxl_out, fe: frame_end, c: cyc});
    if (frame_end && !valid_out) stray_fe++;
  end

  // Signed comparison of two encodings read as sign-magnitude integers.
  function automatic int sm_cmp(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'({33'b0, a[30:0]});
    sb = longint'({33'b0, b[30:0]});
    if (a[31]) sa = -sa;
    if (b[31]) sb = -sb;
    if (sa > sb) return 1;
    if (sa < sb) return -1;
    return 0;
  endfunction

  function automatic logic [31:0] int_to_f32(input int unsigned k);
    int unsigned e;
    logic [31:0] m;
    if (k == 0) return 32'h0;
    e = 0;
    while ((k >> (e + 1)) != 0) e++;
    m = (k << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(e + 127), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_pix();
    case ($urandom_range(9))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return 32'h7FC0_0000;
      5: return 32'hFFC0_0000;
      6: return 32'h3F80_0000;
      7: return 32'hBF80_0000;
      default: return $urandom;
    endcase
  endfunction

  // kind 0 ramp, 1 negatives, 2 signed-zero tie, 3 random
  function automatic logic [31:0] gen_pix(input int kind, input int unsigned k);
    case (kind)
      0: return int_to_f32(k);
      1: return (k == D + 1) ? 32'hBF00_0000 : 32'hBF80_0000;
      2: return (k == 2 * D + 2) ? 32'h0000_0000 : 32'h8000_0000;
      default: return rand_pix();
    endcase
  endfunction

  // Reference model: store the pixel, and when it closes a window take the
  // max over the nine stored pixels in raster order, keeping the first on ties.
  task automatic model_accept(input logic [31:0] px, input int unsigned c);
    logic [31:0] best;
    fr[mrow][mcol] = px;
    if (mrow >= 2 && mcol >= 2 && mrow % 2 == 0 && mcol % 2 == 0) begin
      best = fr[mrow-2][mcol-2];
      for (int r = mrow - 2; r <= mrow; r++)
        for (int cc = mcol - 2; cc <= mcol; cc++)
          if (sm_cmp(fr[r][cc], best) > 0) best = fr[r][cc];
`ifdef MAXPOOL_RELU_EN
      if (best[31]) best = 32'h0;
`endif
      exp_q.push_back('{v: best, fe: (mrow == D - 1 && mcol == D - 1), c: c + 2});
    end
    mcol++;
    if (mcol == D) begin
      mcol = 0;
      mrow++;
      if (mrow == D) mrow = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] px);
    @(negedge clk);
    valid_in = v;
    pxl_in   = px;
    @(posedge clk);
    #1;
    if (v) model_accept(px, cyc);
  endtask

  task automatic drain();
    repeat (5) drive(1'b0, $urandom);
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
  endtask

  // gap_mode 0 contiguous, 1 valid low every third cycle, 2 random gaps
  task automatic feed_frame(input int kind, input int gap_mode);
    int unsigned t;
    t = 0;
    for (int unsigned k = 0; k < NPIX; k++) begin
      if (gap_mode == 1) begin
        while (t % 3 == 2) begin
          drive(1'b0, $urandom);
          t++;
        end
      end else if (gap_mode == 2) begin
        while ($urandom_range(3) == 0) drive(1'b0, $urandom);
      end
      drive(1'b1, gen_pix(kind, k));
      t++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    valid_in = 1'b0;
    pxl_in   = '0;
    #1;
    n_cmp++;
    if (pxl_out !== 32'h0) begin n_bad++; $display("FAIL reset_pxl_out: got %h want 00000000", pxl_out); end
    n_cmp++;
    if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    n_cmp++;
    if (frame_end !== 1'b0) begin n_bad++; $display("FAIL reset_frame_end: got %b want 0", frame_end); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drain();
    n_cmp++;
    if (got_q.size() != 0) begin n_bad++; $display("FAIL reset_idle_pulses: got %0d want 0", got_q.size()); end
    clear_queues();
  endtask

  task automatic test_ramp();
    clear_queues();
    feed_frame(0, 0);
    drain();
    n_cmp++;
    if (got_q.size() != NOUT || exp_q.size() != NOUT) begin
      n_bad++; $display("FAIL ramp_count: got %0d model %0d want %0d", got_q.size(), exp_q.size(), NOUT);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].fe !== exp_q[i].fe || got_q[i].c != exp_q[i].c) begin
        n_bad++;
        $display("FAIL ramp[%0d]: got v=%h fe=%b cyc=%0d want v=%h fe=%b cyc=%0d", i,
                 got_q[i].v, got_q[i].fe, got_q[i].c, exp_q[i].v, exp_q[i].fe, exp_q[i].c);
      end
    end
    if (got_q.size() == NOUT) begin
      n_cmp++;
      if (got_q[0].v !== 32'h4290_0000) begin n_bad++; $display("FAIL ramp_first: got %h want 42900000", got_q[0].v); end
      n_cmp++;
      if (got_q[NOUT-1].v !== 32'h4499_0000 || got_q[NOUT-1].fe !== 1'b1) begin
        n_bad++; $display("FAIL ramp_last: got %h fe=%b want 44990000 fe=1", got_q[NOUT-1].v, got_q[NOUT-1].fe);
      end
    end
    // pxl_out must hold the last result while idle
    n_cmp++;
    if (valid_out !== 1'b0 || pxl_out !== 32'h4499_0000) begin
      n_bad++; $display("FAIL ramp_hold: got v=%h valid=%b want 44990000 valid=0", pxl_out, valid_out);
    end
  endtask

  task automatic test_negatives();
    logic [31:0] first_w, rest_w;
`ifdef MAXPOOL_RELU_EN
    first_w = 32'h0; rest_w = 32'h0;
`else
    first_w = 32'hBF00_0000; rest_w = 32'hBF80_0000;
`endif
    clear_queues();
    feed_frame(1, 0);
    drain();
    n_cmp++;
    if (got_q.size() != NOUT) begin n_bad++; $display("FAIL neg_count: got %0d want %0d", got_q.size(), NOUT); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].fe !== exp_q[i].fe || got_q[i].c != exp_q[i].c) begin
        n_bad++;
        $display("FAIL neg[%0d]: got v=%h fe=%b cyc=%0d want v=%h fe=%b cyc=%0d", i,
                 got_q[i].v, got_q[i].fe, got_q[i].c, exp_q[i].v, exp_q[i].fe, exp_q[i].c);
      end
    end
    if (got_q.size() == NOUT) begin
      n_cmp++;
      if (got_q[0].v !== first_w) begin n_bad++; $display("FAIL neg_first: got %h want %h", got_q[0].v, first_w); end
      n_cmp++;
      if (got_q[1].v !== rest_w) begin n_bad++; $display("FAIL neg_second: got %h want %h", got_q[1].v, rest_w); end
    end
  endtask

  task automatic test_signed_zero();
    logic [31:0] first_w;
`ifdef MAXPOOL_RELU_EN
    first_w = 32'h0;
`else
    first_w = 32'h8000_0000;
`endif
    clear_queues();
    feed_frame(2, 0);
    drain();
    n_cmp++;
    if (got_q.size() != NOUT) begin n_bad++; $display("FAIL zero_count: got %0d want %0d", got_q.size(), NOUT); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].fe !== exp_q[i].fe || got_q[i].c != exp_q[i].c) begin
        n_bad++;
        $display("FAIL zero[%0d]: got v=%h fe=%b cyc=%0d want v=%h fe=%b cyc=%0d", i,
                 got_q[i].v, got_q[i].fe, got_q[i].c, exp_q[i].v, exp_q[i].fe, exp_q[i].c);
      end
    end
    if (got_q.size() > 0) begin
      n_cmp++;
      if (got_q[0].v !== first_w) begin n_bad++; $display("FAIL zero_first: got %h want %h", got_q[0].v, first_w); end
    end
  endtask

  task automatic test_gaps();
    clear_queues();
    feed_frame(0, 1);
    drain();
    n_cmp++;
    if (got_q.size() != NOUT) begin n_bad++; $display("FAIL gaps_count: got %0d want %0d", got_q.size(), NOUT); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].fe !== exp_q[i].fe || got_q[i].c != exp_q[i].c) begin
        n_bad++;
        $display("FAIL gaps[%0d]: got v=%h fe=%b cyc=%0d want v=%h fe=%b cyc=%0d", i,
                 got_q[i].v, got_q[i].fe, got_q[i].c, exp_q[i].v, exp_q[i].fe, exp_q[i].c);
      end
    end
  endtask

  task automatic test_reset_midframe();
    rec_t keep[$];
    int unsigned n_pre;
    clear_queues();
    for (int unsigned k = 0; k < 500; k++) drive(1'b1, gen_pix(0, k));
    // Reset lands before any in-flight window can emerge; those are dropped.
    @(negedge clk);
    valid_in = 1'b0;
    reset    = 1'b0;
    #1;
    n_cmp++;
    if (pxl_out !== 32'h0 || valid_out !== 1'b0 || frame_end !== 1'b0) begin
      n_bad++; $display("FAIL midreset_clear: got v=%h valid=%b fe=%b want 00000000 0 0", pxl_out, valid_out, frame_end);
    end
    foreach (exp_q[i]) if (exp_q[i].c <= cyc) keep.push_back(exp_q[i]);
    exp_q = keep;
    n_pre = exp_q.size();
    mrow = 0;
    mcol = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drain();
    n_cmp++;
    if (got_q.size() != n_pre) begin
      n_bad++; $display("FAIL midreset_quiet: got %0d pulses want %0d", got_q.size(), n_pre);
    end
    feed_frame(0, 0);
    drain();
    n_cmp++;
    if (got_q.size() != n_pre + NOUT) begin
      n_bad++; $display("FAIL midreset_count: got %0d want %0d", got_q.size(), n_pre + NOUT);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].fe !== exp_q[i].fe || got_q[i].c != exp_q[i].c) begin
        n_bad++;
        $display("FAIL midreset[%0d]: got v=%h fe=%b cyc=%0d want v=%h fe=%b cyc=%0d", i,
                 got_q[i].v, got_q[i].fe, got_q[i].c, exp_q[i].v, exp_q[i].fe, exp_q[i].c);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned n_fe;
    clear_queues();
    stray_fe = 0;
    feed_frame(0, 0);
    feed_frame(0, 0);
    drain();
    n_cmp++;
    if (got_q.size() != 2 * NOUT) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), 2 * NOUT); end
    n_fe = 0;
    foreach (got_q[i]) if (got_q[i].fe) n_fe++;
    n_cmp++;
    if (n_fe != 2) begin n_bad++; $display("FAIL b2b_frame_end: got %0d want 2", n_fe); end
    n_cmp++;
    if (stray_fe != 0) begin n_bad++; $display("FAIL b2b_stray_fe: got %0d want 0", stray_fe); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].fe !== exp_q[i].fe || got_q[i].c != exp_q[i].c) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got v=%h fe=%b cyc=%0d want v=%h fe=%b cyc=%0d", i,
                 got_q[i].v, got_q[i].fe, got_q[i].c, exp_q[i].v, exp_q[i].fe, exp_q[i].c);
      end
    end
  endtask

  task automatic test_random();
    clear_queues();
    for (int f = 0; f < 2; f++) feed_frame(3, 2);
    drain();
    n_cmp++;
    if (got_q.size() != 2 * NOUT) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), 2 * NOUT); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i].v !== exp_q[i].v || got_q[i].fe !== exp_q[i].fe || got_q[i].c != exp_q[i].c) begin
        n_bad++;
        $display("FAIL rand[%0d]: got v=%h fe=%b cyc=%0d want v=%h fe=%b cyc=%0d", i,
                 got_q[i].v, got_q[i].fe, got_q[i].c, exp_q[i].v, exp_q[i].fe, exp_q[i].c);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negatives();
    test_signed_zero();
    test_gaps();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
